// File: rtl/xy2_point_buffer_pkg.sv
// Shared constants and FSM encoding for the XY2-100 point buffer.
package xy2_point_buffer_pkg;

  localparam int unsigned XY2_DATA_W = 16;
  localparam int unsigned XY2_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } xy2_fsm_e;

endpackage

// File: rtl/xy2_point_buffer_if.sv
// Point-buffer bus: scan-side strobe, control, and transmitter handshake signals.
interface xy2_point_buffer_if
  import xy2_point_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = XY2_DATA_W,
  parameter int unsigned ADDR_W = XY2_ADDR_W
);

  logic [DATA_W-1:0] x_coord;
  logic [DATA_W-1:0] y_coord;
  logic              xy2_send;
  logic              flush;
  logic              clr_ovf;
  logic              txdone;
  logic              xy2_state;
  logic [DATA_W-1:0] x_data;
  logic [DATA_W-1:0] y_data;
  logic              send_en;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_empty;
  logic              overflow;

  modport master (
    output x_coord, y_coord, xy2_send, flush, clr_ovf, txdone, xy2_state,
    input  x_data, y_data, send_en, fifo_count, fifo_empty, overflow
  );

  modport slave (
    input  x_coord, y_coord, xy2_send, flush, clr_ovf, txdone, xy2_state,
    output x_data, y_data, send_en, fifo_count, fifo_empty, overflow
  );

endinterface

// File: rtl/xy2_point_fifo.sv
// Synchronous FIFO with async-read storage, occupancy count and sticky overflow.
module xy2_point_fifo #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  input  logic              clr_ovf_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, do_pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && !flush_i && (!full || do_pop);
  assign drop    = push_i && !flush_i && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/xy2_point_buffer.sv
// Elastic point buffer feeding the XY2-100 transmitter one frame at a time.
module xy2_point_buffer
  import xy2_point_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = XY2_DATA_W,
  parameter int unsigned ADDR_W = XY2_ADDR_W
) (
  input logic               clk,
  input logic               reset,
  xy2_point_buffer_if.slave bus
);

  xy2_fsm_e            state_q, state_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                send_en_q, send_en_d;
  logic                pop;
  logic [2*DATA_W-1:0] head;
  logic [ADDR_W:0]     count;
  logic                empty;
  logic                overflow;

  xy2_point_fifo #(
    .WIDTH  (2*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (bus.flush),
    .push_i     (bus.xy2_send),
    .wdata_i    ({bus.x_coord, bus.y_coord}),
    .pop_i      (pop),
    .clr_ovf_i  (bus.clr_ovf),
    .rdata_o    (head),
    .count_o    (count),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      send_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      send_en_q <= send_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && !bus.xy2_state)         state_d = REQ;
      REQ:     if (bus.xy2_state)                    state_d = BUSY;
      BUSY:    if (bus.txdone || !bus.xy2_state)     state_d = IDLE;
      default:                                       state_d = IDLE;
    endcase
  end

  // send_en is registered from the next state, so it drops on the same edge the FSM enters BUSY.
  always_comb begin
    pop       = (state_q == IDLE) && (state_d == REQ);
    x_d       = x_q;
    y_d       = y_q;
    send_en_d = (state_d == REQ);
    if (pop) begin
      x_d = head[2*DATA_W-1:DATA_W];
      y_d = head[DATA_W-1:0];
    end
  end

  assign bus.x_data     = x_q;
  assign bus.y_data     = y_q;
  assign bus.send_en    = send_en_q;
  assign bus.fifo_count = count;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_xy2_point_buffer.sv
// Directed bench for xy2_point_buffer with a simple XY2 transmitter model.
module tb_xy2_point_buffer;

  logic clk;
  logic rst;
  logic hold;
  logic tx_ignore;
  logic tx_busy;
  logic txdone_m;
  int   tx_cnt;
  int   frame_len;
  int   n_total;
  int   n_bad;
  int   peak;
  logic track;
  int   sen_rises;
  logic sen_prev;
  int   rises0;
  logic [15:0] sent_x[$];
  logic [15:0] sent_y[$];

  xy2_point_buffer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  xy2_point_buffer #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  assign bus.xy2_state = tx_busy | hold;
  assign bus.txdone    = txdone_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: accepts send_en, stays busy frame_len cycles, then pulses txdone.
  always @(negedge clk) begin
    if (rst) begin
      tx_busy  = 1'b0;
      txdone_m = 1'b0;
      tx_cnt   = 0;
    end else begin
      txdone_m = 1'b0;
      if (tx_busy) begin
        if (tx_cnt <= 1) begin
          tx_busy  = 1'b0;
          txdone_m = 1'b1;
        end else begin
          tx_cnt = tx_cnt - 1;
        end
      end else if (bus.send_en && !tx_ignore) begin
        tx_busy = 1'b1;
        tx_cnt  = frame_len;
        sent_x.push_back(bus.x_data);
        sent_y.push_back(bus.y_data);
      end
    end
  end

  always @(negedge clk) begin
    if (track && int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    if (bus.send_en && !sen_prev) sen_rises = sen_rises + 1;
    sen_prev = bus.send_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pt(input logic [15:0] x, input logic [15:0] y);
    bus.x_coord  = x;
    bus.y_coord  = y;
    bus.xy2_send = 1'b1;
    @(negedge clk);
    bus.xy2_send = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k;
    k = 0;
    while (sent_x.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_sent", sent_x.size(), n);
  endtask

  task automatic clear_sent();
    sent_x.delete();
    sent_y.delete();
  endtask

  initial begin
    n_total = 0; n_bad = 0; peak = 0; track = 1'b0;
    sen_rises = 0; sen_prev = 1'b0;
    rst = 1'b1; hold = 1'b0; tx_ignore = 1'b0; frame_len = 5;
    tx_busy = 1'b0; txdone_m = 1'b0; tx_cnt = 0;
    bus.x_coord = '0; bus.y_coord = '0; bus.xy2_send = 1'b0;
    bus.flush = 1'b0; bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_en", bus.send_en, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_ovf", bus.overflow, 0);
    check("rst_x", bus.x_data, 0);
    check("rst_y", bus.y_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single point: strobe in cycle N, send_en/x_data at N+2
    push_pt(16'h1234, 16'hABCD);
    check("single_cnt_n1", bus.fifo_count, 1);
    check("single_sen_n1", bus.send_en, 0);
    @(negedge clk);
    check("single_sen_n2", bus.send_en, 1);
    check("single_x_n2", bus.x_data, 16'h1234);
    check("single_y_n2", bus.y_data, 16'hABCD);
    check("single_cnt_n2", bus.fifo_count, 0);
    @(negedge clk);
    check("single_sen_drop", bus.send_en, 0);
    wait_sent(1, 20);
    repeat (frame_len + 4) @(negedge clk);
    check("single_sent_x", sent_x[0], 16'h1234);
    check("single_sent_y", sent_y[0], 16'hABCD);
    check("single_idle_sen", bus.send_en, 0);
    check("single_idle_empty", bus.fifo_empty, 1);

    // Burst of 10 with 20-cycle frames
    clear_sent();
    frame_len = 20; peak = 0; track = 1'b1;
    for (int i = 0; i < 10; i++) push_pt(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    repeat (3) @(negedge clk);
    track = 1'b0;
    check("burst_peak", peak, 9);
    wait_sent(10, 400);
    for (int i = 0; i < 10; i++) begin
      check("burst_x", sent_x[i], 16'h1000 + 16'(i));
      check("burst_y", sent_y[i], 16'h2000 + 16'(i));
    end
    repeat (frame_len + 5) @(negedge clk);
    check("burst_ovf", bus.overflow, 0);
    check("burst_empty", bus.fifo_empty, 1);

    // Overflow: 20 strobes with transmitter held busy
    clear_sent();
    frame_len = 3; hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) push_pt(16'h3000 + 16'(i), 16'h3100 + 16'(i));
    check("ovf_count", bus.fifo_count, 16);
    check("ovf_flag", bus.overflow, 1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("ovf_clr", bus.overflow, 0);
    bus.clr_ovf = 1'b1;
    push_pt(16'h3FFF, 16'h3FFF);
    bus.clr_ovf = 1'b0;
    check("ovf_set_wins", bus.overflow, 1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("ovf_clr2", bus.overflow, 0);
    hold = 1'b0;
    wait_sent(16, 300);
    repeat (10) @(negedge clk);
    check("ovf_sent_total", sent_x.size(), 16);
    for (int i = 0; i < 16; i++) check("ovf_order_x", sent_x[i], 16'h3000 + 16'(i));
    check("ovf_drained", bus.fifo_count, 0);

    // Full FIFO with simultaneous pop accepts the strobe
    clear_sent();
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push_pt(16'h4000 + 16'(i), 16'h4100 + 16'(i));
    check("fp_full", bus.fifo_count, 16);
    hold = 1'b0;
    push_pt(16'h40FF, 16'h41FF);
    check("fp_count", bus.fifo_count, 16);
    check("fp_ovf", bus.overflow, 0);
    wait_sent(17, 300);
    repeat (10) @(negedge clk);
    check("fp_first", sent_x[0], 16'h4000);
    check("fp_last_x", sent_x[16], 16'h40FF);
    check("fp_last_y", sent_y[16], 16'h41FF);

    // Flush during BUSY, with a coincident strobe
    clear_sent();
    frame_len = 20; hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) push_pt(16'h5000 + 16'(i), 16'h5100 + 16'(i));
    hold = 1'b0;
    repeat (4) @(negedge clk);
    check("fl_pre_count", bus.fifo_count, 5);
    check("fl_pre_sen", bus.send_en, 0);
    bus.flush = 1'b1;
    push_pt(16'h5EEE, 16'h5EEE);
    bus.flush = 1'b0;
    check("fl_count", bus.fifo_count, 0);
    check("fl_empty", bus.fifo_empty, 1);
    check("fl_ovf", bus.overflow, 0);
    rises0 = sen_rises;
    repeat (40) @(negedge clk);
    check("fl_frame_done", sent_x.size(), 1);
    check("fl_frame_x", sent_x[0], 16'h5000);
    check("fl_no_req", sen_rises, rises0);
    check("fl_x_held", bus.x_data, 16'h5000);
    push_pt(16'h5ABC, 16'h5DEF);
    wait_sent(2, 40);
    check("fl_new_x", sent_x[1], 16'h5ABC);
    repeat (frame_len + 5) @(negedge clk);

    // Asynchronous reset while in REQ with 5 points stored
    clear_sent();
    tx_ignore = 1'b1; hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) push_pt(16'h6000 + 16'(i), 16'h6100 + 16'(i));
    hold = 1'b0;
    @(negedge clk);
    check("rq_sen", bus.send_en, 1);
    check("rq_count", bus.fifo_count, 5);
    #2 rst = 1'b1;
    #1;
    check("rq_rst_sen", bus.send_en, 0);
    check("rq_rst_count", bus.fifo_count, 0);
    check("rq_rst_x", bus.x_data, 0);
    check("rq_rst_empty", bus.fifo_empty, 1);
    @(negedge clk);
    rst = 1'b0;
    tx_ignore = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/xy2_point_buffer.md
Name: xy2_point_buffer

Overview:
- Elastic point buffer between the scan-source selector and the XY2-100 serial transmitter.
- Captures each (x,y) point strobed by the active scan generator into a small FIFO.
- Issues points to the transmitter one frame at a time using its busy/done handshake, so a point strobe that arrives during a frame is never lost.
- Reports fill level and a sticky overflow flag to the control logic.

Parameters:
- DATA_W, 16, width of each X and Y coordinate
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16 points)

Ports:
- clk  in  1  system clock (50 MHz domain of the scan/XY2 logic)
- reset  in  1  asynchronous, active-high reset
- x_coord  in  DATA_W  X coordinate from the scan selector
- y_coord  in  DATA_W  Y coordinate from the scan selector
- xy2_send  in  1  one-cycle point strobe; x/y are valid in the same cycle
- flush  in  1  synchronous FIFO clear
- clr_ovf  in  1  clears the sticky overflow flag
- txdone  in  1  one-cycle pulse from the transmitter at end of frame
- xy2_state  in  1  transmitter busy level (high while a frame is shifting)
- x_data  out  DATA_W  X coordinate presented to the transmitter
- y_data  out  DATA_W  Y coordinate presented to the transmitter
- send_en  out  1  frame request to the transmitter
- fifo_count  out  ADDR_W+1  number of points stored, 0..2**ADDR_W
- fifo_empty  out  1  high when fifo_count == 0
- overflow  out  1  sticky; set when a strobe is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = count = 0; FSM = IDLE.
  - x_data = y_data = 0; send_en = 0; overflow = 0; fifo_empty = 1.
  - Reset mid-frame abandons the frame; the transmitter is reset by the same signal.
- Write side:
  - xy2_send=1 and (not full, or a pop occurs in the same cycle) -> write {x,y} at wr_ptr; wr_ptr wraps modulo depth.
  - Full without a same-cycle pop -> point dropped; overflow set the next cycle.
- Overflow flag:
  - clr_ovf clears it.
  - clr_ovf and a new drop in the same cycle -> overflow stays 1 (set wins).
- Count:
  - count +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - Pointers are ADDR_W bits; count is ADDR_W+1 bits.
- No write-to-read bypass: a point written into an empty FIFO in cycle N appears in count at N+1.
- FSM states:
  - IDLE: if !fifo_empty and xy2_state==0 -> pop the head; register x_data/y_data from the head at the clock edge; go to REQ.
  - REQ: send_en=1. Hold until xy2_state==1, then go to BUSY with send_en=0 in that same cycle. x_data/y_data are held stable.
  - BUSY: wait for txdone==1 or xy2_state falling to 0, then go to IDLE. x_data/y_data are held until the next pop.
- Latency: strobe at cycle N into an empty FIFO with an idle transmitter -> pop at N+1, x_data valid and send_en=1 at N+2.
- Throughput: at most one point per transmitter frame. Back-to-back frames need one IDLE cycle between BUSY and REQ.
- Flush:
  - Clears the pointers and count the next cycle.
  - Does not abort REQ/BUSY; the frame in progress completes with the held data.
  - Flush and xy2_send in the same cycle -> flush wins; the point is discarded and overflow is unaffected.
- send_en is a registered output, never combinational from inputs.
- Storage: inferred distributed RAM with synchronous write and asynchronous read. The head word is registered into x_data/y_data at the pop edge.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, REQ, BUSY), 2-bit encoding.
  - Default DATA_W and ADDR_W constants.
- One natural sub-module: xy2_point_fifo. It holds the generic sync FIFO (storage, pointers, count, full/empty, overflow).
- The top level holds the handshake FSM and the output registers.

Test Plan:
- Reset: assert reset mid-REQ with 5 points stored -> send_en=0, fifo_count=0, x_data=0 immediately (asynchronous).
- Single point: strobe (0x1234, 0xABCD) into the empty FIFO with an idle transmitter model.
  - send_en=1 and x_data=0x1234 at N+2.
  - send_en drops the cycle the model raises xy2_state.
  - Back in IDLE after txdone.
- Burst ordering: strobe 10 points in consecutive cycles while the model's frame lasts 20 cycles.
  - fifo_count peaks at 9.
  - Points leave in FIFO order, one per frame.
  - overflow stays 0.
- Overflow: strobe 20 points with the transmitter held busy.
  - fifo_count saturates at 16; overflow=1.
  - Points 17-20 are dropped; points 1-16 are sent in order.
  - clr_ovf clears overflow.
- Full plus simultaneous pop: with count=16, strobe in the same cycle as a pop -> point accepted, count stays 16, overflow stays 0.
- Flush mid-frame: 6 points stored, flush during BUSY.
  - count=0 next cycle.
  - The current frame completes.
  - No further send_en until a new strobe arrives.
